// File: rtl/afifo_wr_ptr_ctrl_if.sv
// Write-side handshake/status bundle between the async FIFO write controller and its writer.
// ovf/ovf_clr exist only when OVERFLOW_STICKY_EN is defined.
interface afifo_wr_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              wr_req;
    logic              wr_en;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr_gray;
    logic [ADDR_W:0]   rptr_gray_async;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
`ifdef OVERFLOW_STICKY_EN
    logic              ovf;
    logic              ovf_clr;

    modport master (
        input  wr_req, rptr_gray_async, ovf_clr,
        output wr_en, waddr, wptr_gray, full, almost_full, wr_level, ovf
    );
    modport slave (
        output wr_req, rptr_gray_async, ovf_clr,
        input  wr_en, waddr, wptr_gray, full, almost_full, wr_level, ovf
    );
`else
    modport master (
        input  wr_req, rptr_gray_async,
        output wr_en, waddr, wptr_gray, full, almost_full, wr_level
    );
    modport slave (
        output wr_req, rptr_gray_async,
        input  wr_en, waddr, wptr_gray, full, almost_full, wr_level
    );
`endif
endinterface

// File: rtl/afifo_wr_ptr_ctrl.sv
// Async FIFO write-domain pointer controller: binary/Gray write pointer, read-pointer synchroniser, full/almost_full/level.
// wr_en = wr_req & ~full combinationally (zero latency accept); flags settle the cycle after a write. OVERFLOW_STICKY_EN adds sticky ovf.
module afifo_wr_ptr_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    afifo_wr_ptr_ctrl_if.master  bus
);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LP_AFULL = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W:0] r_wbin;
    logic [ADDR_W:0] r_wptr_gray;
    logic [ADDR_W:0] r_rq [SYNC_STAGES];

    logic [ADDR_W:0] w_rs;
    logic [ADDR_W:0] w_rbin_s;
    logic [ADDR_W:0] w_wbin_nxt;
    logic [ADDR_W:0] w_level;
    logic            w_full;
    logic            w_wr_en;

    assign w_rs       = r_rq[SYNC_STAGES-1];
    assign w_wbin_nxt = r_wbin + LP_ONE;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin_s = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            w_rbin_s[i] = ^(w_rs >> i);
        end
    end

    assign w_full  = (r_wptr_gray == {~w_rs[ADDR_W:ADDR_W-1], w_rs[ADDR_W-2:0]});
    assign w_level = r_wbin - w_rbin_s;
    assign w_wr_en = bus.wr_req & ~w_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbin      <= '0;
            r_wptr_gray <= '0;
        end else if (w_wr_en) begin
            r_wbin      <= w_wbin_nxt;
            r_wptr_gray <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_rq[i] <= '0;
            end
        end else begin
            r_rq[0] <= bus.rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_rq[i] <= r_rq[i-1];
            end
        end
    end

`ifdef OVERFLOW_STICKY_EN
    logic r_ovf;

    // A rejected request on the same edge as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_req & w_full) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.wr_en       = w_wr_en;
    assign bus.waddr       = r_wbin[ADDR_W-1:0];
    assign bus.wptr_gray   = r_wptr_gray;
    assign bus.full        = w_full;
    assign bus.wr_level    = w_level;
    assign bus.almost_full = (w_level >= LP_AFULL);
endmodule

// File: tb/tb_afifo_wr_ptr_ctrl.sv
// Directed bench for afifo_wr_ptr_ctrl with ADDR_W=4, SYNC_STAGES=2, AFULL_THRESH=12.
module tb_afifo_wr_ptr_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    afifo_wr_ptr_ctrl_if #(.ADDR_W(4)) bus ();

    afifo_wr_ptr_ctrl #(
        .ADDR_W      (4),
        .SYNC_STAGES (2),
        .AFULL_THRESH(12)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [4:0] wb;
        logic [4:0] prev_g;
        logic       seen_wrap;
        int         exp_lvl;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.wr_req = 1'b0;
        bus.rptr_gray_async = '0;
`ifdef OVERFLOW_STICKY_EN
        bus.ovf_clr = 1'b0;
`endif
        #2;
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wgray", bus.wptr_gray, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_level", bus.wr_level, 0);
        chk("rst_afull", bus.almost_full, 0);
        chk("rst_wr_en", bus.wr_en, 0);
`ifdef OVERFLOW_STICKY_EN
        chk("rst_ovf", bus.ovf, 0);
`endif

        // Fill from empty: 16 accepted writes, then full.
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_req = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("fill_waddr%0d", i), bus.waddr, i % 16);
            chk($sformatf("fill_wgray%0d", i), bus.wptr_gray, gray(5'(i)));
            chk($sformatf("fill_level%0d", i), bus.wr_level, i);
            chk($sformatf("fill_afull%0d", i), bus.almost_full, (i >= 12) ? 1 : 0);
            chk($sformatf("fill_full%0d", i), bus.full, (i == 16) ? 1 : 0);
            chk($sformatf("fill_wr_en%0d", i), bus.wr_en, (i == 16) ? 0 : 1);
        end
        chk("full_wgray", bus.wptr_gray, 5'b11000);

        // Requests while full are refused and leave the pointer frozen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("ovr_wr_en", bus.wr_en, 0);
            chk("ovr_waddr", bus.waddr, 0);
            chk("ovr_wgray", bus.wptr_gray, 5'b11000);
            chk("ovr_level", bus.wr_level, 16);
`ifdef OVERFLOW_STICKY_EN
            chk("ovr_ovf", bus.ovf, 1);
`endif
        end
`ifdef OVERFLOW_STICKY_EN
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        #1;
        chk("ovf_set_wins", bus.ovf, 1);
        bus.wr_req = 1'b0;
        @(negedge clk);
        #1;
        chk("ovf_cleared", bus.ovf, 0);
        bus.ovf_clr = 1'b0;
`endif
        bus.wr_req = 1'b0;

        // Read pointer advances to 4: visible exactly two edges later.
        @(negedge clk);
        bus.rptr_gray_async = 5'b00110;
        @(negedge clk);
        #1;
        chk("sync1_full", bus.full, 1);
        chk("sync1_level", bus.wr_level, 16);
        @(negedge clk);
        #1;
        chk("sync2_full", bus.full, 0);
        chk("sync2_level", bus.wr_level, 12);
        chk("sync2_afull", bus.almost_full, 1);

        // 40 writes with the read pointer trailing by 8; crosses the 31->0 wrap.
        wb = 5'd16;
        prev_g = gray(wb);
        seen_wrap = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            bus.wr_req = 1'b1;
            bus.rptr_gray_async = gray(wb - 5'd8);
            #1;
            exp_lvl = (n == 0) ? 12 : (n == 1) ? 13 : 10;
            chk($sformatf("run_waddr%0d", n), bus.waddr, wb[3:0]);
            chk($sformatf("run_wgray%0d", n), bus.wptr_gray, gray(wb));
            chk($sformatf("run_level%0d", n), bus.wr_level, exp_lvl);
            chk($sformatf("run_wr_en%0d", n), bus.wr_en, 1);
            if (n > 0) chk($sformatf("run_ham%0d", n), $countones(prev_g ^ bus.wptr_gray), 1);
            if (wb == 5'd0 && bus.wptr_gray == 5'd0) seen_wrap = 1'b1;
            prev_g = bus.wptr_gray;
            wb = wb + 5'd1;
        end
        chk("run_wrap_seen", seen_wrap, 1);

        // Asynchronous reset in the middle of the burst, between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_waddr", bus.waddr, 0);
        chk("mid_rst_wgray", bus.wptr_gray, 0);
        chk("mid_rst_full", bus.full, 0);
        chk("mid_rst_level", bus.wr_level, 0);
        chk("mid_rst_wr_en", bus.wr_en, 1);
        bus.wr_req = 1'b0;
        #1;
        chk("mid_rst_wr_en0", bus.wr_en, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
